// File: rtl/msg_pkg.sv
// Shared constants and state type for the message packer datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package msg_pkg;

  // Message capacity in characters and the matching packed width.
  localparam int MSG_CHARS = 10;
  localparam int MSG_W     = 8 * MSG_CHARS;

  // Control bytes recognised by the packer.
  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  // IDLE: working buffer empty. FILL: 1..MAX_CHARS-1 characters held.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } pack_state_t;

endpackage

// File: rtl/message_packer.sv
// Packs an ASCII byte stream into fixed-width messages for the encryptor; PACKER_BACKSPACE_EN enables 8'h08 as delete.
// Latency: code_out/code_done update on the edge after the completing byte (terminator or last slot) is accepted.
// Backpressure: in_ready = !clr only; every byte offered while clr is low is consumed.
module message_packer
  import msg_pkg::*;
#(
  parameter int         MAX_CHARS = MSG_CHARS,
  parameter logic [7:0] TERM_CHAR = ASCII_CR
) (
  input  logic                   msclk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   clr,
  output logic [8*MAX_CHARS-1:0] code_out,
  output logic                   code_done,
  output logic [3:0]             char_count
);

  // Index of the slot whose write completes a message.
  localparam logic [3:0] LAST_SLOT = 4'(MAX_CHARS - 1);

  pack_state_t            state;
  logic [8*MAX_CHARS-1:0] work_buf;
  logic [8*MAX_CHARS-1:0] stored_buf;
  logic                   accept;
  logic                   is_nul;
  logic                   is_term;

  // clr is the only reason to refuse a byte, so it also makes clr win over in_valid.
  assign in_ready = !clr;
  assign accept   = in_valid && in_ready;
  assign is_nul   = (in_data == ASCII_NUL);
  assign is_term  = (in_data == TERM_CHAR);

  // Working buffer with the incoming byte placed at slot char_count (slot 0 is the MSB byte).
  always_comb begin
    stored_buf = work_buf;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (char_count == 4'(i)) begin
        stored_buf[8*(MAX_CHARS-1-i) +: 8] = in_data;
      end
    end
  end

`ifdef PACKER_BACKSPACE_EN
  logic                   is_bs;
  logic [8*MAX_CHARS-1:0] erased_buf;

  assign is_bs = (in_data == ASCII_BS);

  // Working buffer with the most recently stored slot (char_count-1) zeroed.
  always_comb begin
    erased_buf = work_buf;
    for (int i = 0; i < MAX_CHARS; i++) begin
      if (char_count == 4'(i + 1)) begin
        erased_buf[8*(MAX_CHARS-1-i) +: 8] = 8'h00;
      end
    end
  end
`endif

  // Packer FSM: collects bytes, publishes complete messages, honours clr; all outputs registered.
  always_ff @(posedge msclk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      work_buf   <= '0;
      char_count <= 4'd0;
      code_out   <= '0;
      code_done  <= 1'b0;
    end else begin
      code_done <= 1'b0;
      if (clr) begin
        // Drop the partial message; the last published message stays on code_out.
        state      <= IDLE;
        work_buf   <= '0;
        char_count <= 4'd0;
      end else if (accept && !is_nul) begin
        // NUL marks empty slots downstream, so it is never stored and never changes state.
        if (is_term) begin
          // A terminator on an empty buffer would publish an empty message; ignore it.
          if (state == FILL) begin
            code_out   <= work_buf;
            code_done  <= 1'b1;
            work_buf   <= '0;
            char_count <= 4'd0;
            state      <= IDLE;
          end
        end
`ifdef PACKER_BACKSPACE_EN
        else if (is_bs) begin
          if (state == FILL) begin
            work_buf   <= erased_buf;
            char_count <= char_count - 4'd1;
            state      <= (char_count == 4'd1) ? IDLE : FILL;
          end
        end
`endif
        else if (char_count == LAST_SLOT) begin
          // Filling the last slot completes the message without waiting for a terminator.
          code_out   <= stored_buf;
          code_done  <= 1'b1;
          work_buf   <= '0;
          char_count <= 4'd0;
          state      <= IDLE;
        end else begin
          work_buf   <= stored_buf;
          char_count <= char_count + 4'd1;
          state      <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_message_packer.sv
// Self-checking bench for message_packer: vector table plus clr and reset sequences, scoreboarded code_out.
// Latency: expects code_out/code_done one edge after the completing byte.
// Backpressure: drives clr together with in_valid to confirm the byte is refused.
module tb_message_packer;
  import msg_pkg::*;

  logic             msclk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             clr = 1'b0;
  logic             in_ready;
  logic [MSG_W-1:0] code_out;
  logic             code_done;
  logic [3:0]       char_count;

  message_packer #(.MAX_CHARS(MSG_CHARS), .TERM_CHAR(ASCII_CR)) dut (
    .msclk      (msclk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .clr        (clr),
    .code_out   (code_out),
    .code_done  (code_done),
    .char_count (char_count)
  );

  always #5 msclk = ~msclk;

  int total = 0;
  int passed = 0;
  int done_seen = 0;

  // Reference model: characters of the message in progress, last published word, pending publishes.
  logic [7:0]       mq[$];
  logic [MSG_W-1:0] last_out = '0;
  logic [MSG_W-1:0] sb[$];

  typedef struct {
    string            name;
    logic [127:0]     bytes;
    int               n;
    logic [MSG_W-1:0] exp;
    int               dones;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [MSG_W-1:0] pack_model();
    logic [MSG_W-1:0] w;
    w = '0;
    for (int i = 0; i < mq.size(); i++) w[MSG_W-1-8*i -: 8] = mq[i];
    return w;
  endfunction

  task automatic complete_msg();
    last_out = pack_model();
    sb.push_back(last_out);
    mq.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'h00) return;
    if (b == ASCII_CR) begin
      if (mq.size() > 0) complete_msg();
      return;
    end
`ifdef PACKER_BACKSPACE_EN
    if (b == ASCII_BS) begin
      if (mq.size() > 0) void'(mq.pop_back());
      return;
    end
`endif
    mq.push_back(b);
    if (mq.size() == MSG_CHARS) complete_msg();
  endtask

  // Offer one byte for one cycle, update the model, and check count and held output.
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge msclk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    model_byte(b);
    check("char_count", MSG_W'(char_count), MSG_W'(mq.size()));
    check("code_out_hold", code_out, last_out);
  endtask

  task automatic set_vec(input int idx, input string name, input logic [127:0] bytes,
                         input int n, input logic [MSG_W-1:0] exp, input int dones);
    vecs[idx].name  = name;
    vecs[idx].bytes = bytes;
    vecs[idx].n     = n;
    vecs[idx].exp   = exp;
    vecs[idx].dones = dones;
  endtask

  // Every code_done pulse must match a publish the model predicted.
  always @(negedge msclk) begin
    if (code_done === 1'b1) begin
      done_seen++;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL done_pulse: got unexpected code_done with code_out=%h expected no pulse", code_out);
      end else begin
        check("scoreboard", code_out, sb.pop_front());
      end
    end
  end

  initial begin
    logic [MSG_W-1:0] bs_exp;
    int d0;
`ifdef PACKER_BACKSPACE_EN
    bs_exp = 80'h41424300000000000000;
`else
    bs_exp = 80'h41425808430000000000;
`endif
    set_vec(0, "hello_cr",   128'({"HELLO", 8'h0D}),               6,  80'h48454C4C4F0000000000, 1);
    set_vec(1, "ten_chars",  128'("ABCDEFGHIJ"),                   10, 80'h4142434445464748494A, 1);
    set_vec(2, "k_cr",       128'({"K", 8'h0D}),                   2,  80'h4B000000000000000000, 1);
    set_vec(3, "cr_nul",     128'({8'h0D, 8'h00}),                 2,  80'h4B000000000000000000, 0);
    set_vec(4, "backspace",  128'({"ABX", 8'h08, "C", 8'h0D}),     6,  bs_exp,                  1);

    // Reset state while rst is held.
    #3;
    check("rst_code_out", code_out, '0);
    check("rst_code_done", MSG_W'(code_done), '0);
    check("rst_char_count", MSG_W'(char_count), '0);
    #19 rst = 1'b0;
    @(posedge msclk);
    #1;
    check("in_ready_idle", MSG_W'(in_ready), MSG_W'(1));

    for (int v = 0; v < 5; v++) begin
      d0 = done_seen;
      for (int i = 0; i < vecs[v].n; i++) send(vecs[v].bytes[8*(vecs[v].n-1-i) +: 8]);
      repeat (2) @(posedge msclk);
      #1;
      check({vecs[v].name, "_code_out"}, code_out, vecs[v].exp);
      check({vecs[v].name, "_dones"}, MSG_W'(done_seen - d0), MSG_W'(vecs[v].dones));
      check({vecs[v].name, "_count"}, MSG_W'(char_count), '0);
    end

    // clr together with in_valid: the byte is refused and the partial message dropped.
    send("A");
    send("B");
    in_data  = "C";
    in_valid = 1'b1;
    clr      = 1'b1;
    #1;
    check("clr_in_ready", MSG_W'(in_ready), '0);
    @(posedge msclk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    mq.delete();
    check("clr_count", MSG_W'(char_count), '0);
    check("clr_code_out_kept", code_out, last_out);
    send("Z");
    send(ASCII_CR);
    repeat (2) @(posedge msclk);
    #1;
    check("clr_then_z", code_out, 80'h5A000000000000000000);

    // Asynchronous reset mid-message, checked before any clock edge.
    send("A");
    send("B");
    #2 rst = 1'b1;
    #1;
    check("arst_code_out", code_out, '0);
    check("arst_code_done", MSG_W'(code_done), '0);
    check("arst_char_count", MSG_W'(char_count), '0);
    mq.delete();
    last_out = '0;
    #2 rst = 1'b0;
    @(posedge msclk);
    #1;
    send("Q");
    send(ASCII_CR);
    repeat (2) @(posedge msclk);
    #1;
    check("arst_then_q", code_out, 80'h51000000000000000000);

    repeat (3) @(posedge msclk);
    #1;
    check("scoreboard_drained", MSG_W'(sb.size()), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
